// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit.
// Contents: FSM state encoding (also exported on state_dbg), instruction
// opcode/funct constants, and the mux-select and ALU-op encodings that the
// control FSM drives into the datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_BRV    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_R      = 6'b000000;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FUNCT_BRV = 6'b010100;

    // ALU B-input select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // {aluop1, aluop0} to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM and the multicycle datapath.
// master: the control unit (reads IR fields, zero flag, memory ready; drives
//         every mux select, write enable and the ALU-op pair).
// slave:  the datapath/memory side.
//
// Memory handshake: the control unit holds memread (or memwrite) and iord
// steady for as long as it wants an access; the access completes on the
// rising edge at which mem_ready is 1. mem_ready has no meaning while neither
// memread nor memwrite is asserted.
interface multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       aluop1;
    logic       aluop0;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
               irwrite, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop1, aluop0
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
               irwrite, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop1, aluop0
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait timer for the multicycle control unit.
// Ports: clk, reset (async, active high), waiting (FSM is in a memory-access
// state), mem_ready (access completes this cycle), timeout (combinational:
// this wait cycle brings the count to its maximum with no ready, so the FSM
// must abandon the access at this edge).
module mem_wait_timer #(
    parameter int WAIT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);
    localparam logic [WAIT_W-1:0] CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] CNT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

    logic [WAIT_W-1:0] count;

    // Leaving a wait state always coincides with ready, a timeout or
    // waiting dropping, so clearing on those covers every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!waiting || mem_ready) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    // Ready in the same cycle wins over the timeout.
    assign timeout = waiting && !mem_ready && (count == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath (lw, sw, R-type,
// brv, beq, j). Sequences the shared ALU, unified memory, IR, register file
// and PC; memory accesses are bounded by mem_wait_timer.
// Ports: clk, reset (async, active high), bus (master side of
// multicycle_control_if: IR fields, zero, mem_ready in; datapath controls
// out), trap (one-cycle pulse on illegal opcode or memory timeout),
// state_dbg (current state encoding).
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        bus,
    output logic                        trap,
    output logic [3:0]                  state_dbg
);
    state_t state;
    state_t state_next;
    logic   waiting;
    logic   timeout;
    logic   zero_unused;

    // Branch gating on zero happens in the datapath; the FSM never reads it.
    assign zero_unused = bus.zero;

    assign waiting   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign state_dbg = state;

    mem_wait_timer #(.WAIT_W(WAIT_W)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready)  state_next = S_DECODE;
                else if (timeout)   state_next = S_TRAP;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_R:         state_next = (bus.funct == FUNCT_BRV) ? S_BRV : S_EXEC;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (bus.mem_ready)  state_next = S_MEMWB;
                else if (timeout)   state_next = S_TRAP;
            end
            S_MEMWR: begin
                if (bus.mem_ready)  state_next = S_FETCH;
                else if (timeout)   state_next = S_TRAP;
            end
            S_EXEC:   state_next = S_RWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore decode; FETCH irwrite/pcwrite follow mem_ready so the IR and PC
    // only load on the edge that completes the fetch. Everything is held low
    // while reset is asserted.
    always_comb begin
        bus.pcwrite                = 1'b0;
        bus.pcwritecond            = 1'b0;
        bus.iord                   = 1'b0;
        bus.memread                = 1'b0;
        bus.memwrite               = 1'b0;
        bus.memtoreg               = 1'b0;
        bus.irwrite                = 1'b0;
        bus.regdst                 = 1'b0;
        bus.regwrite               = 1'b0;
        bus.alusrca                = 1'b0;
        bus.alusrcb                = SRCB_B;
        bus.pcsource               = PCSRC_ALU;
        {bus.aluop1, bus.aluop0}   = ALUOP_ADD;
        trap                       = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.memread = 1'b1;
                    bus.alusrcb = SRCB_FOUR;
                    bus.irwrite = bus.mem_ready;
                    bus.pcwrite = bus.mem_ready;
                end
                S_DECODE: bus.alusrcb = SRCB_IMM_SH2;
                S_MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_EXEC: begin
                    bus.alusrca              = 1'b1;
                    {bus.aluop1, bus.aluop0} = ALUOP_RTYPE;
                end
                S_RWB: begin
                    bus.alusrca              = 1'b1;
                    {bus.aluop1, bus.aluop0} = ALUOP_RTYPE;
                    bus.regdst               = 1'b1;
                    bus.regwrite             = 1'b1;
                end
                S_BRV: begin
                    // rt is zero for brv, so the R-type add passes rs to the PC.
                    bus.alusrca              = 1'b1;
                    {bus.aluop1, bus.aluop0} = ALUOP_RTYPE;
                    bus.pcwrite              = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrca              = 1'b1;
                    {bus.aluop1, bus.aluop0} = ALUOP_SUB;
                    bus.pcwritecond          = 1'b1;
                    bus.pcsource             = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    bus.pcwrite  = 1'b1;
                    bus.pcsource = PCSRC_JUMP;
                end
                S_TRAP:   trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int W = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic       trap;
    logic [3:0] state_dbg;

    multicycle_control_if bus();

    multicycle_control #(.WAIT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .trap     (trap),
        .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];

    // Reference control table: {state, pcwrite, pcwritecond, iord, memread,
    // memwrite, memtoreg, irwrite, regdst, regwrite, alusrca, alusrcb,
    // pcsource, aluop1, aluop0, trap}
    function automatic logic [W-1:0] model(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, mtr, irw, rd, rw, asa, tr;
        logic [1:0] asb, pcs, aop;
        {pcw, pcwc, iord, mr, mw, mtr, irw, rd, rw, asa, tr} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; mtr = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin asa = 1; aop = 2'b10; rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; aop = 2'b10; pcw = 1; end
            4'd11: tr = 1;
            default: ;
        endcase
        return {st, pcw, pcwc, iord, mr, mw, mtr, irw, rd, rw, asa, asb, pcs, aop, tr};
    endfunction

    function automatic logic [W-1:0] obs();
        return {state_dbg, bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread,
                bus.memwrite, bus.memtoreg, bus.irwrite, bus.regdst, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, trap};
    endfunction

    // driver: schedule one cycle: expected outputs to the scoreboard, ready level to the driver queue
    task automatic plan(input logic [3:0] st, input logic rdy);
        exp_q.push_back(model(st, rdy));
        rdy_q.push_back(rdy);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct);
        bus.op    = op;
        bus.funct = funct;
    endtask

    task automatic test_reset();
        logic [W-1:0] got;
        reset = 1'b1;
        @(negedge clk);
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", got, {W{1'b0}});
        end
        #2 reset = 1'b0;
        #1 got = obs();
        vectors++;
        if (got !== model(4'd0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", got, model(4'd0, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(OP_LW, 6'd0);
        plan(4'd0, 1); plan(4'd1, 0); plan(4'd2, 0); plan(4'd3, 1); plan(4'd4, 0);
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL lw cycle %0d: got %h expected %h", n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_sw_wait();
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(OP_SW, 6'd0);
        plan(4'd0, 1); plan(4'd1, 0); plan(4'd2, 0);
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) plan(4'd5, 0);
        plan(4'd5, 1);
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sw_wait cycle %0d: got %h expected %h", n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_rtype(input logic [5:0] funct);
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(OP_R, funct);
        plan(4'd0, 1); plan(4'd1, 0);
        if (funct == FUNCT_BRV) plan(4'd10, 0);
        else begin plan(4'd6, 0); plan(4'd7, 0); end
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rtype funct=%b cycle %0d: got %h expected %h", funct, n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_branch_jump(input logic [5:0] op, input logic z);
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(op, 6'($urandom_range(0, 63)));
        bus.zero = z;
        plan(4'd0, 1); plan(4'd1, 0);
        if (op == OP_BEQ)     plan(4'd8, 0);
        else if (op == OP_J)  plan(4'd9, 0);
        else                  plan(4'd11, 0);
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL op=%b zero=%b cycle %0d: got %h expected %h", op, z, n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    // waits: number of ready-low cycles in the wait state; ready_last gives
    // ready on the following cycle instead of letting the timeout fire
    task automatic test_timeout(input logic in_fetch, input int waits, input logic ready_last);
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(OP_LW, 6'd0);
        if (in_fetch) begin
            plan(4'd0, 1); plan(4'd4, 0);          // lw already mid-flight: finish via MEMRD below is skipped
            exp_q.delete(); rdy_q.delete();
            for (int i = 0; i < waits; i++) plan(4'd0, 0);
            if (ready_last) begin plan(4'd0, 1); plan(4'd1, 0); plan(4'd2, 0); plan(4'd3, 1); plan(4'd4, 0); end
            else plan(4'd11, 0);
        end else begin
            plan(4'd0, 1); plan(4'd1, 0); plan(4'd2, 0);
            for (int i = 0; i < waits; i++) plan(4'd3, 0);
            if (ready_last) begin plan(4'd3, 1); plan(4'd4, 0); end
            else plan(4'd11, 0);
        end
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL timeout fetch=%0b ready_last=%0b cycle %0d: got %h expected %h",
                         in_fetch, ready_last, n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [W-1:0] got, exp;
        int n = 0;
        set_instr(OP_SW, 6'd0);
        plan(4'd0, 1); plan(4'd1, 0); plan(4'd2, 0); plan(4'd5, 0);
        while (exp_q.size() > 0) begin
            bus.mem_ready = rdy_q.pop_front();
            @(negedge clk);
            got = obs(); exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid setup cycle %0d: got %h expected %h", n, got, exp);
            end
            @(posedge clk); #1; n++;
        end
        // still in MEMWR (ready low); raise reset between edges
        #2;
        vectors++;
        if (bus.memwrite !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid pre memwrite: got %b expected 1", bus.memwrite);
        end
        reset = 1'b1;
        #1 got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_mid async: got %h expected %h", got, {W{1'b0}});
        end
        @(posedge clk); #1 got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_mid held: got %h expected %h", got, {W{1'b0}});
        end
        reset = 1'b0;
        #1 got = obs();
        vectors++;
        if (got !== model(4'd0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_mid release: got %h expected %h", got, model(4'd0, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype(6'b100000);
        test_rtype(FUNCT_BRV);
        test_branch_jump(OP_BEQ, 1'b0);
        test_branch_jump(OP_BEQ, 1'b1);
        test_branch_jump(OP_J, 1'b0);
        test_branch_jump(6'b111111, 1'b0);
        test_timeout(1'b0, 15, 1'b0);
        test_timeout(1'b0, 14, 1'b1);
        test_timeout(1'b1, 15, 1'b0);
        test_timeout(1'b1, 14, 1'b1);
        test_reset_mid_memwr();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
